// File: rtl/rv32v_div_pkg.sv
// ---------------------------------------------------------------------------
// rv32v_div_pkg
// Shared types and helpers for the vector integer divide front end.
//   div_op_t    : element operation encoding (bit0 = signed, bit1 = remainder)
//   sew_t       : selected element width (reserved encoding behaves as e32)
//   seq_state_t : sequencer FSM states
//   sew_extend  : sign/zero-extend the low SEW bits of a value to full width
//   sew_min_neg : most-negative SEW value, sign-extended to full width
//   sew_ones    : SEW-wide all-ones pattern, zero-extended to full width
// ---------------------------------------------------------------------------
package rv32v_div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIVU = 2'd0,
        OP_DIV  = 2'd1,
        OP_REMU = 2'd2,
        OP_REM  = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        SEW_E8   = 2'd0,
        SEW_E16  = 2'd1,
        SEW_E32  = 2'd2,
        SEW_RSVD = 2'd3
    } sew_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [DIV_XLEN-1:0] sew_extend(input logic [DIV_XLEN-1:0] v,
                                                       input sew_t sew,
                                                       input logic sgn);
        case (sew)
            SEW_E8:  sew_extend = {{(DIV_XLEN-8){sgn & v[7]}}, v[7:0]};
            SEW_E16: sew_extend = {{(DIV_XLEN-16){sgn & v[15]}}, v[15:0]};
            default: sew_extend = v;
        endcase
    endfunction

    function automatic logic [DIV_XLEN-1:0] sew_min_neg(input sew_t sew);
        case (sew)
            SEW_E8:  sew_min_neg = {{(DIV_XLEN-7){1'b1}}, 7'b0};
            SEW_E16: sew_min_neg = {{(DIV_XLEN-15){1'b1}}, 15'b0};
            default: sew_min_neg = {1'b1, {(DIV_XLEN-1){1'b0}}};
        endcase
    endfunction

    function automatic logic [DIV_XLEN-1:0] sew_ones(input sew_t sew);
        case (sew)
            SEW_E8:  sew_ones = {{(DIV_XLEN-8){1'b0}}, 8'hFF};
            SEW_E16: sew_ones = {{(DIV_XLEN-16){1'b0}}, 16'hFFFF};
            default: sew_ones = {DIV_XLEN{1'b1}};
        endcase
    endfunction

endpackage

// File: rtl/rv32v_div_sequencer_divider.sv
// ---------------------------------------------------------------------------
// rv32v_divider
// Radix-4 restoring divider core: two quotient bits per cycle, ITERS cycles.
//   CLK, nRST     : clock, asynchronous active-low reset
//   i_start       : load operands and begin (restarts even if already busy)
//   i_is_signed   : treat operands as two's complement
//   i_dividend    : dividend, sampled on the i_start edge
//   i_divisor     : divisor, sampled on the i_start edge
//   o_quotient    : quotient, valid while o_finished is high
//   o_remainder   : remainder, valid while o_finished is high
//   o_finished    : set with the last iteration, cleared by the next start
// ---------------------------------------------------------------------------
module rv32v_divider #(
    parameter int NUM_BITS = 32,
    parameter int ITERS    = NUM_BITS / 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                i_start,
    input  logic                i_is_signed,
    input  logic [NUM_BITS-1:0] i_dividend,
    input  logic [NUM_BITS-1:0] i_divisor,
    output logic [NUM_BITS-1:0] o_quotient,
    output logic [NUM_BITS-1:0] o_remainder,
    output logic                o_finished
);

    localparam int CW = $clog2(ITERS);

    logic [NUM_BITS-1:0] r_dvd, r_div, r_quo, r_rem;
    logic [CW-1:0]       r_count;
    logic                r_busy, r_finished, r_negQ, r_negR;

    logic [NUM_BITS-1:0] w_absDvd, w_absDiv, w_next;
    logic [NUM_BITS+1:0] w_shift, w_d1, w_d2, w_d3;
    logic [1:0]          w_digit;

    // One radix-4 step: bring down two dividend bits and subtract the largest
    // multiple (0..3) of the divisor that fits. 3d still fits in NUM_BITS+2.
    always_comb begin
        w_absDvd = (i_is_signed && i_dividend[NUM_BITS-1]) ? -i_dividend : i_dividend;
        w_absDiv = (i_is_signed && i_divisor[NUM_BITS-1])  ? -i_divisor  : i_divisor;
        w_shift  = {r_rem, r_dvd[NUM_BITS-1 -: 2]};
        w_d1     = {2'b00, r_div};
        w_d2     = {1'b0, r_div, 1'b0};
        w_d3     = w_d1 + w_d2;
        if (w_shift >= w_d3) begin
            w_digit = 2'd3;
            w_next  = NUM_BITS'(w_shift - w_d3);
        end else if (w_shift >= w_d2) begin
            w_digit = 2'd2;
            w_next  = NUM_BITS'(w_shift - w_d2);
        end else if (w_shift >= w_d1) begin
            w_digit = 2'd1;
            w_next  = NUM_BITS'(w_shift - w_d1);
        end else begin
            w_digit = 2'd0;
            w_next  = NUM_BITS'(w_shift);
        end
    end

    // Iteration control; a start always reloads, so an abandoned divide from
    // a flushed op never leaks into the next one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dvd      <= '0;
            r_div      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
        end else if (i_start) begin
            r_dvd      <= w_absDvd;
            r_div      <= w_absDiv;
            r_quo      <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_finished <= 1'b0;
            r_negQ     <= i_is_signed & (i_dividend[NUM_BITS-1] ^ i_divisor[NUM_BITS-1]);
            r_negR     <= i_is_signed & i_dividend[NUM_BITS-1];
        end else if (r_busy) begin
            r_dvd   <= r_dvd << 2;
            r_quo   <= {r_quo[NUM_BITS-3:0], w_digit};
            r_rem   <= w_next;
            r_count <= r_count + 1'b1;
            if (r_count == CW'(ITERS - 1)) begin
                r_busy     <= 1'b0;
                r_finished <= 1'b1;
            end
        end
    end

    assign o_quotient  = r_negQ ? -r_quo : r_quo;
    assign o_remainder = r_negR ? -r_rem : r_rem;
    assign o_finished  = r_finished;

endmodule

// File: rtl/rv32v_div_sequencer.sv
// ---------------------------------------------------------------------------
// rv32v_div_sequencer
// Element-level front end for the vector integer divider. Accepts one
// vdivu/vdiv/vremu/vrem element per handshake, resolves mask and RISC-V
// divide special cases locally, runs ordinary divides through the unsigned
// radix-4 core on magnitudes and fixes up signs on the way out.
//   CLK, nRST          : clock, asynchronous active-low reset
//   in_valid/in_ready  : element op handshake
//   in_op, in_sew      : div_op_t and sew_t encodings
//   in_vs2, in_vs1     : dividend / divisor, element in the low SEW bits
//   in_vd_old, in_mask : prior destination and active-element mask
//   kill               : synchronous flush of in-flight op and pending result
//   out_valid/out_ready: result handshake; out_result held until accepted
//   busy               : op in flight or result pending
// ---------------------------------------------------------------------------
module rv32v_div_sequencer
    import rv32v_div_pkg::*;
#(
    parameter int XLEN       = DIV_XLEN,
    parameter int CORE_ITERS = DIV_XLEN / 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [1:0]      in_sew,
    input  logic [XLEN-1:0] in_vs2,
    input  logic [XLEN-1:0] in_vs1,
    input  logic [XLEN-1:0] in_vd_old,
    input  logic            in_mask,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    seq_state_t      r_state;
    sew_t            r_sew;
    logic [1:0]      r_op;
    logic            r_qNeg, r_rNeg, r_start, r_outValid, r_readyEn;
    logic [XLEN-1:0] r_magA, r_magB, r_result;

    sew_t            w_sew;
    logic            w_signed, w_aNeg, w_bNeg, w_special, w_accept, w_coreFinished;
    logic [XLEN-1:0] w_a, w_b, w_magA, w_magB, w_specialRes;
    logic [XLEN-1:0] w_coreQ, w_coreR, w_fixQ, w_fixR, w_doneRes;

    // Acceptance-side decode. Special cases are resolved here so they never
    // touch the core; priority is mask, then divide-by-zero, then overflow.
    always_comb begin
        w_sew        = sew_t'(in_sew);
        w_signed     = in_op[0];
        w_a          = sew_extend(in_vs2, w_sew, w_signed);
        w_b          = sew_extend(in_vs1, w_sew, w_signed);
        w_aNeg       = w_signed & w_a[XLEN-1];
        w_bNeg       = w_signed & w_b[XLEN-1];
        w_magA       = w_aNeg ? -w_a : w_a;
        w_magB       = w_bNeg ? -w_b : w_b;
        w_special    = 1'b1;
        w_specialRes = '0;
        if (!in_mask) begin
            w_specialRes = in_vd_old;
        end else if (w_b == '0) begin
            w_specialRes = in_op[1] ? w_a : sew_extend(sew_ones(w_sew), w_sew, w_signed);
        end else if (w_signed && (w_a == sew_min_neg(w_sew)) && (w_b == '1)) begin
            w_specialRes = in_op[1] ? '0 : w_a;
        end else begin
            w_special = 1'b0;
        end
    end

    // Completion-side fixup: the core only ever sees magnitudes.
    always_comb begin
        w_fixQ    = r_qNeg ? -w_coreQ : w_coreQ;
        w_fixR    = r_rNeg ? -w_coreR : w_coreR;
        w_doneRes = sew_extend(r_op[1] ? w_fixR : w_fixQ, r_sew, r_op[0]);
    end

    assign w_accept   = in_valid && in_ready;
    assign in_ready   = r_readyEn && (r_state == ST_IDLE) && !r_outValid;
    assign busy       = (r_state != ST_IDLE) || r_outValid;
    assign out_valid  = r_outValid;
    assign out_result = r_result;

    // Sequencer FSM. kill overrides every state transition. Core finished is
    // only looked at in WAIT, so whatever it does between ops is harmless.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_sew      <= SEW_E8;
            r_qNeg     <= 1'b0;
            r_rNeg     <= 1'b0;
            r_magA     <= '0;
            r_magB     <= '0;
            r_start    <= 1'b0;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_readyEn  <= 1'b0;
        end else begin
            r_readyEn <= 1'b1;
            if (kill) begin
                r_state    <= ST_IDLE;
                r_start    <= 1'b0;
                r_outValid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_op   <= in_op;
                            r_sew  <= w_sew;
                            r_qNeg <= w_aNeg ^ w_bNeg;
                            r_rNeg <= w_aNeg;
                            r_magA <= w_magA;
                            r_magB <= w_magB;
                            if (w_special) begin
                                r_result   <= w_specialRes;
                                r_outValid <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                r_start <= 1'b1;
                                r_state <= ST_START;
                            end
                        end
                    end
                    ST_START: begin
                        r_start <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_coreFinished) begin
                            r_result   <= w_doneRes;
                            r_outValid <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            r_outValid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    rv32v_divider #(
        .NUM_BITS (XLEN),
        .ITERS    (CORE_ITERS)
    ) u_divider (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_start     (r_start),
        .i_is_signed (1'b0),
        .i_dividend  (r_magA),
        .i_divisor   (r_magB),
        .o_quotient  (w_coreQ),
        .o_remainder (w_coreR),
        .o_finished  (w_coreFinished)
    );

endmodule

// File: tb/tb_rv32v_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv32v_div_sequencer
// Self-checking bench for rv32v_div_sequencer: a table of hand-derived
// vectors, a randomized batch checked against a behavioural model, and
// hand-written sequences for backpressure, kill and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_rv32v_div_sequencer;
    import rv32v_div_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid, in_ready, in_mask, kill, out_valid, out_ready, busy;
    logic [1:0]  in_op, in_sew;
    logic [31:0] in_vs2, in_vs1, in_vd_old, out_result;

    int checkCount = 0;
    int errCount   = 0;
    int cycCount   = 0;
    int acceptCycle = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sbQ[$];

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sew;
        logic [31:0] vs2;
        logic [31:0] vs1;
        logic [31:0] vd;
        logic        mask;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;
    vec_t vecs[14];

    rv32v_div_sequencer dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_sew     (in_sew),
        .in_vs2     (in_vs2),
        .in_vs1     (in_vs1),
        .in_vd_old  (in_vd_old),
        .in_mask    (in_mask),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycCount <= cycCount + 1;

    // Global time bound so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic longint extModel(input logic [31:0] v, input int w, input logic sgn);
        longint m;
        longint x;
        m = (longint'(1) << w) - 1;
        x = longint'({32'b0, v}) & m;
        if (sgn && x[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Reference behaviour written from the RISC-V definition of vdiv/vrem.
    function automatic logic [31:0] modelResult(input logic [1:0] op, input logic [1:0] sew,
                                                input logic [31:0] vs2, input logic [31:0] vs1,
                                                input logic [31:0] vd, input logic mask,
                                                output int lat);
        int     w;
        logic   sgn;
        longint a, b, q, r, res;
        w   = (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
        sgn = op[0];
        a   = extModel(vs2, w, sgn);
        b   = extModel(vs1, w, sgn);
        lat = 1;
        if (!mask) return vd;
        if (b == 0) begin
            q = -1;
            r = a;
        end else if (sgn && (a == -(longint'(1) << (w - 1))) && (b == -1)) begin
            q = a;
            r = 0;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = 19;
        end
        res = op[1] ? r : q;
        return 32'(extModel(res[31:0], w, sgn));
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] sew,
                                 input logic [31:0] vs2, input logic [31:0] vs1,
                                 input logic [31:0] vd, input logic mask,
                                 input logic [31:0] expRes, input int expLat);
        int guard;
        guard = 0;
        @(negedge CLK);
        in_op     = op;
        in_sew    = sew;
        in_vs2    = vs2;
        in_vs1    = vs1;
        in_vd_old = vd;
        in_mask   = mask;
        in_valid  = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (!in_ready) begin
            checkEq("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        acceptCycle = cycCount;
        in_valid    = 1'b0;
        sbQ.push_back('{expRes, expLat});
    endtask

    task automatic checkOutput(input string name, input bit doHandshake);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge CLK);
        while (!out_valid && guard < 60) begin
            @(negedge CLK);
            guard++;
        end
        e = '{32'hxxxxxxxx, -1};
        if (sbQ.size() > 0) e = sbQ.pop_front();
        checkEq({name, "_valid"}, 32'(out_valid), 32'd1);
        checkEq({name, "_result"}, out_result, e.res);
        checkEq({name, "_latency"}, 32'(cycCount - acceptCycle + 1), 32'(e.lat));
        if (doHandshake) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int seen;
        int handshakeCycle;

        vecs[0]  = '{OP_DIVU, SEW_E32,  32'd100,       32'd7,         32'h0, 1'b1, 32'd14,        19, "divu_e32"};
        vecs[1]  = '{OP_REM,  SEW_E8,   32'h123456F9,  32'h00000002,  32'h0, 1'b1, 32'hFFFFFFFF,  19, "rem_e8"};
        vecs[2]  = '{OP_DIV,  SEW_E8,   32'h123456F9,  32'h00000002,  32'h0, 1'b1, 32'hFFFFFFFD,  19, "div_e8"};
        vecs[3]  = '{OP_DIV,  SEW_E16,  32'h00001234,  32'hABCD0000,  32'h0, 1'b1, 32'hFFFFFFFF,  1,  "div_e16_by0"};
        vecs[4]  = '{OP_REMU, SEW_E32,  32'h00001234,  32'h00000000,  32'h0, 1'b1, 32'h00001234,  1,  "remu_e32_by0"};
        vecs[5]  = '{OP_DIV,  SEW_E32,  32'h80000000,  32'hFFFFFFFF,  32'h0, 1'b1, 32'h80000000,  1,  "div_ovf"};
        vecs[6]  = '{OP_REM,  SEW_E32,  32'h80000000,  32'hFFFFFFFF,  32'h0, 1'b1, 32'h00000000,  1,  "rem_ovf"};
        vecs[7]  = '{OP_DIV,  SEW_E32,  32'd100,       32'd7,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF,  1,  "masked"};
        vecs[8]  = '{OP_DIVU, SEW_E8,   32'hAB12CDFF,  32'h00000010,  32'h0, 1'b1, 32'h0000000F,  19, "divu_e8"};
        vecs[9]  = '{OP_DIV,  SEW_E8,   32'h00000080,  32'h000000FF,  32'h0, 1'b1, 32'hFFFFFF80,  1,  "div_e8_ovf"};
        vecs[10] = '{OP_REMU, SEW_E16,  32'h0000FFFF,  32'h00000100,  32'h0, 1'b1, 32'h000000FF,  19, "remu_e16"};
        vecs[11] = '{OP_DIV,  SEW_E16,  32'h00008000,  32'h00000003,  32'h0, 1'b1, 32'hFFFFD556,  19, "div_e16_neg"};
        vecs[12] = '{OP_REMU, SEW_E32,  32'hFFFFFFFF,  32'h00000010,  32'h0, 1'b1, 32'h0000000F,  19, "remu_e32_max"};
        vecs[13] = '{OP_DIVU, SEW_RSVD, 32'd1000,      32'd10,        32'h0, 1'b1, 32'd100,       19, "divu_rsvd_sew"};

        nRST = 1'b0; in_valid = 1'b0; in_op = '0; in_sew = '0; in_vs2 = '0; in_vs1 = '0;
        in_vd_old = '0; in_mask = 1'b0; kill = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        checkEq("rst_out_valid", 32'(out_valid), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        checkEq("rst_out_result", out_result, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        checkEq("rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].sew, vecs[i].vs2, vecs[i].vs1,
                          vecs[i].vd, vecs[i].mask, vecs[i].exp, vecs[i].lat);
            checkOutput(vecs[i].name, 1'b1);
        end
        $display("[TB] table vectors done");

        // Randomized batch against the model
        for (int i = 0; i < 20; i++) begin
            logic [1:0]  op, sew;
            logic [31:0] a, b, vd, e;
            logic        m;
            int          lat;
            op  = 2'($urandom_range(0, 3));
            sew = 2'($urandom_range(0, 3));
            a   = $urandom;
            vd  = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom & 32'hFFFF0000;
                1: begin
                    a = (sew == 2'd0) ? 32'h00000080 : (sew == 2'd1) ? 32'h00008000 : 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                2: b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            m = ($urandom_range(0, 7) != 0);
            e = modelResult(op, sew, a, b, vd, m, lat);
            applyStimulus(op, sew, a, b, vd, m, e, lat);
            checkOutput($sformatf("rand%0d", i), 1'b1);
        end

        // Backpressure: result must hold and input must stay closed
        out_ready = 1'b0;
        applyStimulus(OP_DIVU, SEW_E32, 32'd50, 32'd5, 32'h0, 1'b1, 32'd10, 19);
        checkOutput("bp", 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checkEq($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            checkEq($sformatf("bp_hold_result%0d", i), out_result, 32'd10);
            checkEq($sformatf("bp_hold_in_ready%0d", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        handshakeCycle = cycCount;
        checkEq("bp_release_valid", 32'(out_valid), 32'd0);
        checkEq("bp_release_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(OP_DIVU, SEW_E32, 32'd81, 32'd9, 32'h0, 1'b1, 32'd9, 19);
        checkEq("bp_next_accept", 32'(acceptCycle - handshakeCycle), 32'd1);
        checkOutput("bp_next", 1'b1);

        // kill mid core-op, then wait past the old core finish
        applyStimulus(OP_DIVU, SEW_E32, 32'd1000, 32'd3, 32'h0, 1'b1, 32'd333, 19);
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        kill = 1'b1;
        @(posedge CLK);
        #1;
        kill = 1'b0;
        void'(sbQ.pop_back());
        checkEq("kill_busy", 32'(busy), 32'd0);
        checkEq("kill_out_valid", 32'(out_valid), 32'd0);
        checkEq("kill_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        checkEq("kill_no_output", 32'(seen), 32'd0);
        applyStimulus(OP_DIVU, SEW_E32, 32'd9, 32'd3, 32'h0, 1'b1, 32'd3, 19);
        checkOutput("after_kill", 1'b1);

        // kill early, then immediately restart the still-busy core
        applyStimulus(OP_DIVU, SEW_E32, 32'd777, 32'd7, 32'h0, 1'b1, 32'd111, 19);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        kill = 1'b1;
        @(posedge CLK);
        #1;
        kill = 1'b0;
        void'(sbQ.pop_back());
        applyStimulus(OP_DIVU, SEW_E32, 32'd21, 32'd4, 32'h0, 1'b1, 32'd5, 19);
        checkOutput("restart_after_kill", 1'b1);

        // kill beats a same-cycle in_valid
        @(negedge CLK);
        in_op = OP_DIVU; in_sew = SEW_E32; in_vs2 = 32'd8; in_vs1 = 32'd2; in_mask = 1'b1;
        in_valid = 1'b1;
        kill = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        kill = 1'b0;
        checkEq("kill_vs_valid_busy", 32'(busy), 32'd0);

        // kill drops a pending result held by backpressure
        out_ready = 1'b0;
        applyStimulus(OP_DIVU, SEW_E32, 32'd5, 32'd0, 32'h0, 1'b1, 32'hFFFFFFFF, 1);
        checkOutput("kill_done", 1'b0);
        kill = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        kill = 1'b0;
        checkEq("kill_done_valid", 32'(out_valid), 32'd0);
        checkEq("kill_done_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a core op
        applyStimulus(OP_DIV, SEW_E32, 32'd500, 32'd9, 32'h0, 1'b1, 32'd55, 19);
        repeat (5) @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        void'(sbQ.pop_back());
        checkEq("arst_busy", 32'(busy), 32'd0);
        checkEq("arst_out_valid", 32'(out_valid), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(OP_REM, SEW_E16, 32'h0000FFF6, 32'd4, 32'h0, 1'b1, 32'hFFFFFFFE, 19);
        checkOutput("after_arst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
